ysyx_22040895_mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares the core's single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the IFU/LSU and the memory-access block that issues the pmem read/write calls. It grants one transaction at a time, registers the granted request, drives it to memory with a valid/ready handshake, and routes the single response back to the owner.

---
 rtl/ysyx_22040895_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_ysyx_22040895_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter sharing one memory port, one outstanding transaction.
// Define YSYX_22040895_ARB_RR_EN for round-robin tie-breaking; otherwise LSU has fixed priority.
module ysyx_22040895_mem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_err
);

    localparam int unsigned MASK_W = DATA_W / 8;

`ifdef YSYX_22040895_ARB_RR_EN
    localparam bit FIXED_PRI = 1'b0;
`else
    localparam bit FIXED_PRI = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t state;
    owner_t owner;
    owner_t last_grant;
    logic   grant_lsu_c;
    logic   idle_c;

    // Tie-break: fixed priority always favours LSU; round-robin avoids the last winner.
    always_comb begin
        grant_lsu_c = lsu_req_valid &&
                      (!ifu_req_valid || FIXED_PRI || (last_grant == OWN_IFU));
        idle_c      = rst && (state == S_IDLE);
    end

    assign ifu_req_ready = idle_c && ifu_req_valid && !grant_lsu_c;
    assign lsu_req_ready = idle_c && grant_lsu_c;
    assign mem_req_valid = (state == S_REQ);

    // Responses pass straight through to whoever owns the transaction.
    assign ifu_rsp_valid = (state == S_WAIT) && mem_rsp_valid && (owner == OWN_IFU);
    assign lsu_rsp_valid = (state == S_WAIT) && mem_rsp_valid && (owner == OWN_LSU);
    assign ifu_rdata     = mem_rdata;
    assign lsu_rdata     = mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            arb_err    <= 1'b0;
        end else begin
            if (mem_rsp_valid && (state != S_WAIT)) begin
                arb_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (lsu_req_ready) begin
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        mem_we     <= lsu_we;
                        mem_addr   <= lsu_addr;
                        mem_wdata  <= lsu_wdata;
                        mem_wmask  <= lsu_wmask;
                        state      <= S_REQ;
                    end else if (ifu_req_ready) begin
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        mem_we     <= 1'b0;
                        mem_addr   <= ifu_addr;
                        mem_wdata  <= '0;
                        mem_wmask  <= {MASK_W{1'b1}};
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_mem_arbiter.sv
// Directed self-checking bench for ysyx_22040895_mem_arbiter.
// Tie expectations follow YSYX_22040895_ARB_RR_EN when it is defined for the build.
module tb_ysyx_22040895_mem_arbiter;

`ifdef YSYX_22040895_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, arb_err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22040895_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, arb_err} !== 6'b0) begin
            failures++;
            $display("FAIL rst_ctrl got=%b exp=000000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, arb_err});
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wmask} !== 137'b0) begin
            failures++;
            $display("FAIL rst_payload got we=%b addr=%h wdata=%h wmask=%h exp all zero",
                     mem_we, mem_addr, mem_wdata, mem_wmask);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b000) begin
            failures++;
            $display("FAIL rst_release got=%b exp=000", {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
    endtask

    task automatic test_ifu_read;
        step();
        ifu_req_valid = 1'b1;
        ifu_addr = 64'h8000_0000;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin
            failures++;
            $display("FAIL ifu_accept got=%b exp=100", {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
        step();
        ifu_req_valid = 1'b0;
        ifu_addr = 64'h0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_we, mem_addr, mem_wmask, mem_wdata} !== {1'b1, 1'b0, 64'h8000_0000, 8'hFF, 64'h0}) begin
            failures++;
            $display("FAIL ifu_mem_req got v=%b we=%b addr=%h mask=%h wdata=%h exp v=1 we=0 addr=80000000 mask=ff wdata=0",
                     mem_req_valid, mem_we, mem_addr, mem_wmask, mem_wdata);
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'h0000_0013_0000_0297;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rdata} !== {3'b100, 64'h0000_0013_0000_0297}) begin
            failures++;
            $display("FAIL ifu_rsp got v=%b%b%b data=%h exp v=100 data=0000001300000297",
                     ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rdata);
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, arb_err} !== 3'b000) begin
            failures++;
            $display("FAIL ifu_rsp_end got=%b exp=000", {ifu_rsp_valid, lsu_rsp_valid, arb_err});
        end
    endtask

    task automatic test_lsu_store_stall;
        step();
        lsu_req_valid = 1'b1;
        lsu_we = 1'b1;
        lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF;
        lsu_wmask = 8'h0F;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL st_accept got=%b exp=01", {ifu_req_ready, lsu_req_ready});
        end
        step();
        lsu_req_valid = 1'b0;
        lsu_we = 1'b0;
        lsu_addr = 64'h0;
        lsu_wdata = 64'h1111_2222_3333_4444;
        lsu_wmask = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            checks++;
            if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask} !==
                {1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F}) begin
                failures++;
                $display("FAIL st_hold[%0d] got v=%b we=%b addr=%h wdata=%h mask=%h exp v=1 we=1 addr=80001000 wdata=deadbeef mask=0f",
                         i, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask);
            end
            if (i < 3) step();
        end
        step();
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, lsu_rsp_valid, ifu_rsp_valid, lsu_req_ready, mem_addr} !== {4'b0000, 64'h8000_1000}) begin
            failures++;
            $display("FAIL st_wait got v=%b%b%b%b addr=%h exp v=0000 addr=80001000",
                     mem_req_valid, lsu_rsp_valid, ifu_rsp_valid, lsu_req_ready, mem_addr);
        end
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hFFFF;
        #1;
        checks++;
        if ({lsu_rsp_valid, ifu_rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL st_done got=%b exp=10", {lsu_rsp_valid, ifu_rsp_valid});
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({lsu_rsp_valid, ifu_rsp_valid, arb_err} !== 3'b000) begin
            failures++;
            $display("FAIL st_pulse_end got=%b exp=000", {lsu_rsp_valid, ifu_rsp_valid, arb_err});
        end
    endtask

    task automatic test_tie;
        logic        exp_lsu;
        logic [63:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            exp_lsu  = RR ? ((i % 2) == 1) : 1'b1;
            exp_addr = exp_lsu ? 64'h8000_2000 : 64'h8000_0100;
            step();
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            ifu_addr = 64'h8000_0100;
            lsu_addr = 64'h8000_2000;
            lsu_we = 1'b0;
            lsu_wmask = 8'hFF;
            #1;
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
                failures++;
                $display("FAIL tie_grant[%0d] got=%b exp=%b", i, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
            end
            step();
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            mem_req_ready = 1'b1;
            #1;
            checks++;
            if ({mem_req_valid, mem_addr} !== {1'b1, exp_addr}) begin
                failures++;
                $display("FAIL tie_addr[%0d] got v=%b addr=%h exp v=1 addr=%h", i, mem_req_valid, mem_addr, exp_addr);
            end
            step();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rdata = 64'(i + 5);
            #1;
            checks++;
            if ({ifu_rsp_valid, lsu_rsp_valid} !== {~exp_lsu, exp_lsu} || lsu_rdata !== 64'(i + 5)) begin
                failures++;
                $display("FAIL tie_rsp[%0d] got=%b data=%h exp=%b data=%h", i,
                         {ifu_rsp_valid, lsu_rsp_valid}, lsu_rdata, {~exp_lsu, exp_lsu}, 64'(i + 5));
            end
            step();
            mem_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        step();
        ifu_req_valid = 1'b1;
        ifu_addr = 64'h8000_0200;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept got=%b exp=10", {ifu_req_ready, lsu_req_ready});
        end
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_addr = 64'h8000_3000;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_req got=%b exp=001", {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
        step();
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_wait got=%b exp=00", {ifu_req_ready, lsu_req_ready});
        end
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'h0000_0000_0000_ABCD;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_rsp got=%b exp=0010", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid});
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_idle got=%b exp=01", {ifu_req_ready, lsu_req_ready});
        end
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 64'h8000_3000}) begin
            failures++;
            $display("FAIL b2b_second got v=%b addr=%h exp v=1 addr=80003000", mem_req_valid, mem_addr);
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_second_rsp got=%b exp=01", {ifu_rsp_valid, lsu_rsp_valid});
        end
        step();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait;
        step();
        lsu_req_valid = 1'b1;
        lsu_we = 1'b1;
        lsu_addr = 64'h8000_4000;
        lsu_wdata = 64'h0123_4567_89AB_CDEF;
        lsu_wmask = 8'hFF;
        #1;
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rw_accept got=%b exp=1", lsu_req_ready);
        end
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_we, mem_addr} !== 68'b0) begin
            failures++;
            $display("FAIL rw_in_rst got ctl=%b we=%b addr=%h exp all zero",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid}, mem_we, mem_addr);
        end
        step();
        mem_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, arb_err} !== 3'b000) begin
            failures++;
            $display("FAIL rw_rsp_dropped got=%b exp=000", {ifu_rsp_valid, lsu_rsp_valid, arb_err});
        end
        step();
        mem_rsp_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, arb_err} !== 5'b10000) begin
            failures++;
            $display("FAIL rw_idle got=%b exp=10000",
                     {ifu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, arb_err});
        end
        ifu_req_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL spurious_route got=%b exp=00", {ifu_rsp_valid, lsu_rsp_valid});
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (arb_err !== 1'b1) begin
            failures++;
            $display("FAIL arb_err_set got=%b exp=1", arb_err);
        end
        repeat (3) step();
        checks++;
        if (arb_err !== 1'b1) begin
            failures++;
            $display("FAIL arb_err_sticky got=%b exp=1", arb_err);
        end
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_addr = 64'h0;
        lsu_req_valid = 1'b0;
        lsu_we = 1'b0;
        lsu_addr = 64'h0;
        lsu_wdata = 64'h0;
        lsu_wmask = 8'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = 64'h0;
        repeat (2) step();
        test_reset();
        test_ifu_read();
        test_lsu_store_stall();
        test_tie();
        test_back_to_back();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
